gate_checker: RTL and testbench
===============================

# gate_checker

Sequential truth-table sweeper for the two-input logic gate library. On `start` it drives all four input vectors onto a gate under test and samples the gate output after a programmable settle time. It compares each sample against the expected function selected by `func_sel` and reports per-vector failures. It is the driving/observing end of the gate `a, b -> c` interface and is used for self-test of gate instances in simulation and on FPGA.

## Interface

- `SETTLE`, default 1: extra cycles each vector is held before the gate output is sampled (0 allowed).
- `clk` input 1: rising-edge clock.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: request a sweep; accepted only in IDLE.
- `func_sel` input 3: expected function; latched when `start` is accepted.
  - 0 AND, 1 OR, 2 NOT (on `a`; `b` ignored), 3 NAND, 4 NOR, 5 XOR, 6 XNOR, 7 invalid.
- `dut_c` input 1: output of the gate under test.
- `drv_a` output 1: gate input `a`.
- `drv_b` output 1: gate input `b`.
- `busy` output 1: high during RUN.
- `done` output 1: single-cycle pulse at the end of a sweep.
- `pass` output 1: high when the last sweep had no mismatch.
- `fail_vec` output 4: bit k set if vector k mismatched.

## Operation

- States: IDLE, RUN, DONE. Reset drives the FSM to IDLE.
- Reset values: `drv_a`=0, `drv_b`=0, `busy`=0, `done`=0, `pass`=0, `fail_vec`=0. Settle counter=0, vector index=0.
- IDLE -> RUN on `start`=1 with `func_sel`≠7:
  - latch `func_sel`;
  - clear `fail_vec` and `pass`;
  - set vector index k=0 and settle counter=0.
- IDLE -> DONE on `start`=1 with `func_sel`=7: no sweep; `fail_vec`=4'b1111, `pass`=0.
- RUN: `{drv_a, drv_b}` = k (k=0: 00, 1: 01, 2: 10, 3: 11).
  - The settle counter increments each cycle while below SETTLE.
  - When the counter equals SETTLE, `dut_c` is compared with the expected value and `fail_vec[k]` is set on mismatch. The counter then clears and k increments.
  - After k=3 is sampled: RUN -> DONE.
- DONE: lasts exactly one cycle.
  - `done`=1; `pass` = (`fail_vec`==0), registered on entry to DONE.
  - `drv_a`/`drv_b` = 0.
  - Returns to IDLE unconditionally.
- `pass` and `fail_vec` hold from DONE until the next accepted `start`.
- `start` in RUN or DONE is ignored and not queued.
- `func_sel` changes after acceptance have no effect on the running sweep.
- Mid-sweep `rst`: all outputs return immediately to reset values. The sweep is abandoned with no `done` pulse.

## Timing

- Start accepted at rising edge E0. Vector k is driven from edge E0+k·(SETTLE+1) for SETTLE+1 cycles.
- `dut_c` is sampled at edge E0+(k+1)·(SETTLE+1). The gate under test is combinational, so it has SETTLE+1 cycles to settle.
- `done` is high in the cycle following edge E0+4·(SETTLE+1).
  - SETTLE=1: 8 cycles of RUN, then `done`.
  - SETTLE=0: 4 cycles of RUN, then `done`.
- Invalid `func_sel`: `done` is high in the cycle immediately after E0.
- `busy` is high exactly during RUN cycles.
- All outputs are registered; no combinational path from inputs to outputs.
- Settle counter width: max(1, $clog2(SETTLE+1)).

## Structure

- Shared package `gate_pkg`:
  - `func_sel` encoding constants (FN_AND..FN_XNOR, FN_INV=7);
  - FSM state enum;
  - vector count constant (4).
- Sub-module `gate_expect` (combinational): `func_sel`, `a`, `b` -> expected `c`; returns 0 for code 7.
  - Reused by future gate benches as the golden model.
- Top-level `gate_checker`: FSM, settle counter, vector index, result registers.

## Test plan

- `and_gate` connected, `func_sel`=0, SETTLE=1, pulse `start` -> `busy` for 8 cycles, `done` on the 9th, `pass`=1, `fail_vec`=0000.
- `dut_c` tied 0, `func_sel`=1 (OR) -> `pass`=0, `fail_vec`=1110. Same tie with `func_sel`=4 (NOR) -> `fail_vec`=0001.
- `xnor_gate` connected, `func_sel`=5 (XOR) -> `fail_vec`=1111. Repeat with `func_sel`=6 -> `pass`=1 and `fail_vec` cleared at the new start.
- `func_sel`=7 with `start` -> `done` the next cycle, `busy` never high, `fail_vec`=1111, `pass`=0.
- SETTLE=0, `not_gate` on `drv_a`, `func_sel`=2 -> `done` 4 cycles after acceptance, `pass`=1. `start` held high throughout RUN is ignored; exactly one `done` pulse.
- `rst` asserted during vector 2 -> same-cycle `drv_a`/`drv_b`/`busy`/`pass`/`fail_vec`=0, no `done`. A new `start` after release runs a full clean sweep.

Source files
------------

// File: rtl/gate_pkg.sv
// gate_pkg: shared function codes, FSM states and vector count for the gate checker
package gate_pkg;
  localparam logic [2:0] FN_AND  = 3'd0;
  localparam logic [2:0] FN_OR   = 3'd1;
  localparam logic [2:0] FN_NOT  = 3'd2;
  localparam logic [2:0] FN_NAND = 3'd3;
  localparam logic [2:0] FN_NOR  = 3'd4;
  localparam logic [2:0] FN_XOR  = 3'd5;
  localparam logic [2:0] FN_XNOR = 3'd6;
  localparam logic [2:0] FN_INV  = 3'd7;
  localparam int NUM_VEC = 4;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
endpackage

// File: rtl/gate_expect.sv
// gate_expect: golden two-input gate function selected by func_sel (0 for the invalid code)
module gate_expect
  import gate_pkg::*;
(
  input  logic [2:0] func_sel,
  input  logic       a,
  input  logic       b,
  output logic       c
);
  always_comb begin
    c = func_sel == FN_AND  ? a & b :
        func_sel == FN_OR   ? a | b :
        func_sel == FN_NOT  ? ~a :
        func_sel == FN_NAND ? ~(a & b) :
        func_sel == FN_NOR  ? ~(a | b) :
        func_sel == FN_XOR  ? a ^ b :
        func_sel == FN_XNOR ? ~(a ^ b) : 1'b0;
  end
endmodule

// File: rtl/gate_checker.sv
// gate_checker: sweeps all four input vectors through a gate under test and flags mismatching vectors
module gate_checker
  import gate_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] func_sel,
  input  logic       dut_c,
  output logic       drv_a,
  output logic       drv_b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_vec
);
  localparam int CW = SETTLE > 0 ? $clog2(SETTLE + 1) : 1;
  localparam logic [CW-1:0] SET_Q = CW'(SETTLE);
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [1:0] k;
  logic [2:0] fsel;
  logic exp_c, samp, last;
  logic [3:0] fail_n;
  gate_expect u_exp (.func_sel(fsel), .a(k[1]), .b(k[0]), .c(exp_c));
  always_comb begin
    samp = state == S_RUN && cnt == SET_Q;
    last = samp && k == 2'(NUM_VEC - 1);
    fail_n = fail_vec | ({3'b000, dut_c != exp_c} << k);
    state_n = state == S_IDLE ? (start ? (func_sel == FN_INV ? S_DONE : S_RUN) : S_IDLE) :
              state == S_RUN  ? (last ? S_DONE : S_RUN) : S_IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt <= '0;
      k <= '0;
      fsel <= '0;
      fail_vec <= '0;
      pass <= 1'b0;
    end else begin
      state <= state_n;
      if (state == S_IDLE && start) begin
        fsel <= func_sel;
        cnt <= '0;
        k <= '0;
        fail_vec <= func_sel == FN_INV ? 4'b1111 : 4'b0000;
        pass <= 1'b0;
      end else if (state == S_RUN) begin
        cnt <= samp ? '0 : cnt + 1'b1;
        if (samp) begin
          k <= k + 1'b1;
          fail_vec <= fail_n;
        end
        if (last) pass <= fail_n == 4'b0000;
      end
    end
  end
  assign drv_a = k[1];
  assign drv_b = k[0];
  assign busy = state == S_RUN;
  assign done = state == S_DONE;
endmodule

// File: tb/tb_gate_checker.sv
// tb_gate_checker: randomized scoreboard bench for gate_checker at SETTLE=1 and SETTLE=0
module tb_gate_checker;
  typedef struct packed {logic [3:0] fv; logic ps; logic [7:0] cyc;} exp_t;
  localparam logic [3:0] TT [8] = '{4'b1000, 4'b1110, 4'b0011, 4'b0111, 4'b0001, 4'b0110, 4'b1001, 4'b0000};
  logic clk = 0, rst = 1, start = 0;
  logic [2:0] func_sel = 0;
  logic [3:0] gt = 0;
  logic a0, b0, busy0, done0, pass0, a1, b1, busy1, done1, pass1;
  logic [3:0] fv0, fv1;
  int tests = 0, fails = 0, bc0 = 0, bc1 = 0;
  logic pb0 = 0, pb1 = 0;
  exp_t q0[$], q1[$];
  exp_t e0, e1, last0, last1;
  always #5 clk = ~clk;
  gate_checker #(.SETTLE(1)) u0 (.clk(clk), .rst(rst), .start(start), .func_sel(func_sel), .dut_c(gt[{a0, b0}]),
    .drv_a(a0), .drv_b(b0), .busy(busy0), .done(done0), .pass(pass0), .fail_vec(fv0));
  gate_checker #(.SETTLE(0)) u1 (.clk(clk), .rst(rst), .start(start), .func_sel(func_sel), .dut_c(gt[{a1, b1}]),
    .drv_a(a1), .drv_b(b1), .busy(busy1), .done(done1), .pass(pass1), .fail_vec(fv1));
  task automatic chk(input string n, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  function automatic exp_t model(input logic [2:0] fs, input logic [3:0] g, input int st);
    exp_t e;
    e.fv = fs == 3'd7 ? 4'b1111 : g ^ TT[fs];
    e.ps = fs != 3'd7 && e.fv == 4'b0000;
    e.cyc = fs == 3'd7 ? 8'd0 : 8'(4 * (st + 1));
    return e;
  endfunction
  always @(negedge clk) begin
    if (rst) bc0 = 0;
    else begin
      if (done0) begin
        if (q0.size() == 0) chk("u0_spurious_done", 8'd1, 8'd0);
        else begin
          e0 = q0.pop_front();
          chk("u0_fail_vec", 8'(fv0), 8'(e0.fv));
          chk("u0_pass", 8'(pass0), 8'(e0.ps));
          chk("u0_busy_cycles", 8'(bc0), e0.cyc);
          chk("u0_done_after_run", 8'(pb0), 8'(e0.cyc != 0));
        end
        bc0 = 0;
      end
      if (busy0) bc0++;
    end
    pb0 = busy0;
  end
  always @(negedge clk) begin
    if (rst) bc1 = 0;
    else begin
      if (done1) begin
        if (q1.size() == 0) chk("u1_spurious_done", 8'd1, 8'd0);
        else begin
          e1 = q1.pop_front();
          chk("u1_fail_vec", 8'(fv1), 8'(e1.fv));
          chk("u1_pass", 8'(pass1), 8'(e1.ps));
          chk("u1_busy_cycles", 8'(bc1), e1.cyc);
          chk("u1_done_after_run", 8'(pb1), 8'(e1.cyc != 0));
        end
        bc1 = 0;
      end
      if (busy1) bc1++;
    end
    pb1 = busy1;
  end
  task automatic run(input logic [2:0] fs, input logic [3:0] g, input int hold);
    @(negedge clk);
    gt = g;
    func_sel = fs;
    start = 1;
    last0 = model(fs, g, 1);
    last1 = model(fs, g, 0);
    q0.push_back(last0);
    q1.push_back(last1);
    repeat (hold + 1) @(negedge clk);
    start = 0;
    func_sel = 3'($urandom);
    for (int i = 0; i < 80 && (q0.size() != 0 || q1.size() != 0); i++) @(negedge clk);
    if (q0.size() != 0 || q1.size() != 0) begin
      chk("sweep_timeout", 8'(q0.size() + q1.size()), 8'd0);
      q0.delete();
      q1.delete();
    end
    repeat (2) @(negedge clk);
    chk("u0_hold", {3'b0, pass0, fv0}, {3'b0, last0.ps, last0.fv});
    chk("u1_hold", {3'b0, pass1, fv1}, {3'b0, last1.ps, last1.fv});
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("u0_reset", {a0, b0, busy0, done0, pass0, fv0}, 8'd0);
    chk("u1_reset", {a1, b1, busy1, done1, pass1, fv1}, 8'd0);
    rst = 0;
    run(3'd0, 4'b1000, 0);
    run(3'd1, 4'b0000, 0);
    run(3'd4, 4'b0000, 0);
    run(3'd5, 4'b1001, 0);
    run(3'd6, 4'b1001, 0);
    run(3'd7, 4'b1000, 0);
    run(3'd2, 4'b0011, 4);
    @(negedge clk);
    gt = 4'b1001;
    func_sel = 3'd0;
    start = 1;
    q1.push_back(model(3'd0, 4'b1001, 0));
    @(negedge clk);
    start = 0;
    repeat (4) @(negedge clk);
    chk("u0_mid_sweep", {busy0, a0, b0, fv0}, {3'b110, 4'b0001});
    #2 rst = 1;
    #1;
    chk("u0_async_reset", {a0, b0, busy0, done0, pass0, fv0}, 8'd0);
    chk("u1_async_reset", {a1, b1, busy1, done1, pass1, fv1}, 8'd0);
    q0.delete();
    repeat (2) @(negedge clk);
    chk("u0_reset_no_done", {done0, busy0}, 8'd0);
    rst = 0;
    run(3'd3, 4'b0111, 0);
    for (int i = 0; i < 20; i++) run(3'($urandom_range(0, 7)), 4'($urandom), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
